// File: rtl/aes_sbox_scheduler_if.sv
// aes_sbox_scheduler_if: state/key job handshakes and shared S-box word bus of aes_sbox_scheduler
interface aes_sbox_scheduler_if;
  logic st_valid, st_ready, st_done, kw_valid, kw_ready, kw_done, busy;
  logic [0:127] st_data, st_out;
  logic [0:31] kw_data, kw_out, sb_in, sb_out;
  modport slave (
    input st_valid, st_data, kw_valid, kw_data, sb_out,
    output st_ready, st_done, st_out, kw_ready, kw_done, kw_out, sb_in, busy
  );
  modport master (
    output st_valid, st_data, kw_valid, kw_data, sb_out,
    input st_ready, st_done, st_out, kw_ready, kw_done, kw_out, sb_in, busy
  );
endinterface

// File: rtl/aes_sbox_scheduler.sv
// aes_sbox_scheduler: time-shares one 32-bit S-box word unit between 4-pass SubBytes and 1-pass SubWord jobs.
// Define AES_SBOX_SCHED_RR_EN for round-robin arbitration; otherwise key wins every tie.
module aes_sbox_scheduler (
  input logic clk,
  input logic rst_n,
  aes_sbox_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ST_PASS, KW_PASS} state_t;
  state_t state, state_nx;
  logic [1:0] cnt;
  logic [0:127] st_buf, res;
  logic [0:31] kw_buf;
  logic st_grant, st_acc, kw_acc, last_pass;
`ifdef AES_SBOX_SCHED_RR_EN
  logic last_st;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_st <= 1'b0;
    else if (st_acc || kw_acc) last_st <= st_acc;
  assign st_grant = bus.st_valid && (!bus.kw_valid || !last_st);
`else
  assign st_grant = bus.st_valid && !bus.kw_valid;
`endif
  assign bus.st_ready = state == IDLE && st_grant;
  assign bus.kw_ready = state == IDLE && bus.kw_valid && !st_grant;
  assign st_acc = bus.st_valid && bus.st_ready;
  assign kw_acc = bus.kw_valid && bus.kw_ready;
  assign last_pass = state == ST_PASS && cnt == 2'd3;
  always_comb begin
    state_nx = state == IDLE ? (st_acc ? ST_PASS : kw_acc ? KW_PASS : IDLE) :
               state == ST_PASS && !last_pass ? ST_PASS : IDLE;
    bus.sb_in = state == ST_PASS ? st_buf[{cnt, 5'd0} +: 32] : state == KW_PASS ? kw_buf : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      st_buf <= '0;
      res <= '0;
      kw_buf <= '0;
      bus.st_out <= '0;
      bus.kw_out <= '0;
      bus.st_done <= 1'b0;
      bus.kw_done <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      state <= state_nx;
      bus.busy <= state_nx != IDLE;
      bus.st_done <= last_pass;
      bus.kw_done <= state == KW_PASS;
      if (st_acc) begin
        st_buf <= bus.st_data;
        cnt <= '0;
      end
      if (kw_acc) kw_buf <= bus.kw_data;
      if (state == ST_PASS) begin
        res[{cnt, 5'd0} +: 32] <= bus.sb_out;
        cnt <= cnt + 2'd1;
      end
      if (last_pass) bus.st_out <= {res[0:95], bus.sb_out};
      if (state == KW_PASS) bus.kw_out <= bus.sb_out;
    end
endmodule
